// File: rtl/sw_alloc_rr.sv
// ----------------------------------------------------------------------------
// sw_alloc_rr
//
// Switch allocator for the 5-port router. Every output port runs its own
// round-robin arbiter over the input ports and, once a multi-flit packet has
// won it, stays locked to that input until the tail flit is granted
// (wormhole hold). The registered allocation matrix feeds xbarCtrl.
//
// Ports
//   clk          in   1        clock, all state on the rising edge
//   reset_n      in   1        asynchronous reset, active-low
//   reqVector    in   N*N      [i*N+o]=1: input i requests output o
//   tailVector   in   N        [i]=1: current flit at input i is a tail/single
//   outReady     in   N        [o]=1: downstream of output o accepts a flit
//   allocVector  out  N*N      registered grants, [i*N+o]
//   grantValid   out  N        [i]=1: input i holds a grant (registered)
//   lockVector   out  N        [o]=1: output o is locked to a packet
//
// Port index map: 4-LOCAL, 3-N, 2-S, 1-E, 0-W.
// ----------------------------------------------------------------------------
module sw_alloc_rr #(
    parameter int NUM_PORT     = 5,
    parameter int LOG_NUM_PORT = 3
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORT*NUM_PORT-1:0]     reqVector,
    input  logic [NUM_PORT-1:0]              tailVector,
    input  logic [NUM_PORT-1:0]              outReady,
    output logic [NUM_PORT*NUM_PORT-1:0]     allocVector,
    output logic [NUM_PORT-1:0]              grantValid,
    output logic [NUM_PORT-1:0]              lockVector
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } port_state_t;

    // ------------------------------------------------------------------------
    // Request filtering: an input may only ask for one output. When a row has
    // several bits set, the lowest-index output is the one that counts, so the
    // other outputs never see that input as a requester.
    // ------------------------------------------------------------------------
    logic [NUM_PORT*NUM_PORT-1:0] eff_req;
    logic [NUM_PORT-1:0]          row_seen;

    always_comb begin
        eff_req  = '0;
        row_seen = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            for (int o = 0; o < NUM_PORT; o++) begin
                if (reqVector[i*NUM_PORT+o] && !row_seen[i]) begin
                    eff_req[i*NUM_PORT+o] = 1'b1;
                    row_seen[i]           = 1'b1;
                end
            end
        end
    end

    // Combinational grant matrix, same [i*N+o] layout as allocVector.
    logic [NUM_PORT*NUM_PORT-1:0] alloc_next;

    // ------------------------------------------------------------------------
    // One arbiter + lock FSM per output port.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_out
            port_state_t             state_reg;
            port_state_t             state_next;
            logic [LOG_NUM_PORT-1:0] ptr_reg;
            logic [LOG_NUM_PORT-1:0] ptr_next;
            logic [LOG_NUM_PORT-1:0] owner_reg;
            logic [LOG_NUM_PORT-1:0] owner_next;
            logic [NUM_PORT-1:0]     col_req;     // requesters of this output
            logic [NUM_PORT-1:0]     grant_next;  // one-hot over inputs
            logic [LOG_NUM_PORT-1:0] winner;
            logic                    found;

            for (genvar gj = 0; gj < NUM_PORT; gj++) begin : g_col
                assign col_req[gj]                 = eff_req[gj*NUM_PORT+gi];
                assign alloc_next[gj*NUM_PORT+gi]  = grant_next[gj];
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg <= ST_IDLE;
                    ptr_reg   <= '0;
                    owner_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    ptr_reg   <= ptr_next;
                    owner_reg <= owner_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                ptr_next   = ptr_reg;
                owner_next = owner_reg;
                grant_next = '0;
                winner     = '0;
                found      = 1'b0;

                case (state_reg)
                    ST_IDLE: begin
                        // Pointer only moves when a grant is actually issued;
                        // idle or back-pressured cycles leave it untouched.
                        if (outReady[gi] && (|col_req)) begin
                            for (int k = 0; k < NUM_PORT; k++) begin
                                if (!found && col_req[(int'(ptr_reg) + k) % NUM_PORT]) begin
                                    found  = 1'b1;
                                    winner = LOG_NUM_PORT'((int'(ptr_reg) + k) % NUM_PORT);
                                end
                            end
                            grant_next[winner] = 1'b1;
                            ptr_next = (int'(winner) == NUM_PORT - 1) ? '0 : winner + 1'b1;
                            // Head of a multi-flit packet: hold the output.
                            if (!tailVector[winner]) begin
                                state_next = ST_LOCKED;
                                owner_next = winner;
                            end
                        end
                    end

                    ST_LOCKED: begin
                        // Only the owner may proceed. A stalled or silent
                        // owner keeps the lock indefinitely.
                        if (outReady[gi] && col_req[owner_reg]) begin
                            grant_next[owner_reg] = 1'b1;
                            if (tailVector[owner_reg]) begin
                                state_next = ST_IDLE;
                            end
                        end
                    end

                    default: begin
                        state_next = ST_IDLE;
                    end
                endcase
            end

            assign lockVector[gi] = (state_reg == ST_LOCKED);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Registered allocation matrix and per-input grant flags.
    // ------------------------------------------------------------------------
    logic [NUM_PORT*NUM_PORT-1:0] alloc_reg;
    logic [NUM_PORT-1:0]          grant_valid_reg;
    logic [NUM_PORT-1:0]          grant_valid_next;

    always_comb begin
        grant_valid_next = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            grant_valid_next[i] = |alloc_next[i*NUM_PORT +: NUM_PORT];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alloc_reg       <= '0;
            grant_valid_reg <= '0;
        end else begin
            alloc_reg       <= alloc_next;
            grant_valid_reg <= grant_valid_next;
        end
    end

    assign allocVector = alloc_reg;
    assign grantValid  = grant_valid_reg;

endmodule

// File: tb/tb_sw_alloc_rr.sv
// ----------------------------------------------------------------------------
// tb_sw_alloc_rr
//
// Directed bench for sw_alloc_rr: reset, round-robin fairness, permutation,
// wormhole hold, backpressure, multi-bit request filtering and not-ready
// pointer behaviour. Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point, so each check sees the result of
// the edge just taken.
// ----------------------------------------------------------------------------
module tb_sw_alloc_rr;

    localparam int N = 5;

    logic           clk;
    logic           reset_n;
    logic [N*N-1:0] reqVector;
    logic [N-1:0]   tailVector;
    logic [N-1:0]   outReady;
    logic [N*N-1:0] allocVector;
    logic [N-1:0]   grantValid;
    logic [N-1:0]   lockVector;

    int total;
    int bad;

    sw_alloc_rr #(.NUM_PORT(5), .LOG_NUM_PORT(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .reqVector   (reqVector),
        .tailVector  (tailVector),
        .outReady    (outReady),
        .allocVector (allocVector),
        .grantValid  (grantValid),
        .lockVector  (lockVector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is a fixed number of cycles, this only guards a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Clears stimulus and pulses reset between edges so every scenario starts
    // with all pointers at 0 and no locks.
    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset_n    = 1'b0;
        reqVector  = '0;
        tailVector = '0;
        outReady   = '1;
        #2;
        reset_n    = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reqVector  = 25'($urandom());
        tailVector = 5'($urandom());
        outReady   = '1;
        step();
        step();
        total++;
        if (allocVector !== 25'h0) begin
            bad++;
            $display("FAIL reset_alloc: got %h expected %h", allocVector, 25'h0);
        end
        total++;
        if (grantValid !== 5'b0) begin
            bad++;
            $display("FAIL reset_gv: got %b expected %b", grantValid, 5'b0);
        end
        total++;
        if (lockVector !== 5'b0) begin
            bad++;
            $display("FAIL reset_lock: got %b expected %b", lockVector, 5'b0);
        end
        $display("tx reset_hold alloc=%h gv=%b lock=%b", allocVector, grantValid, lockVector);

        // in1,in3 -> out1 (tail), in0 -> out0 (head, locks out0)
        reqVector  = (25'h1 << 6) | (25'h1 << 16) | 25'h1;
        tailVector = 5'b01010;
        reset_n    = 1'b1;
        step();
        total++;
        if (allocVector !== 25'h41) begin
            bad++;
            $display("FAIL reset_pre_alloc: got %h expected %h", allocVector, 25'h41);
        end
        total++;
        if (lockVector !== 5'b00001) begin
            bad++;
            $display("FAIL reset_pre_lock: got %b expected %b", lockVector, 5'b00001);
        end
        $display("tx reset_pre alloc=%h lock=%b", allocVector, lockVector);

        // Asynchronous pulse between edges.
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (allocVector !== 25'h0) begin
            bad++;
            $display("FAIL reset_async_alloc: got %h expected %h", allocVector, 25'h0);
        end
        total++;
        if (grantValid !== 5'b0) begin
            bad++;
            $display("FAIL reset_async_gv: got %b expected %b", grantValid, 5'b0);
        end
        total++;
        if (lockVector !== 5'b0) begin
            bad++;
            $display("FAIL reset_async_lock: got %b expected %b", lockVector, 5'b0);
        end
        $display("tx reset_async alloc=%h gv=%b lock=%b", allocVector, grantValid, lockVector);
        reqVector = (25'h1 << 6) | (25'h1 << 16);
        #1;
        reset_n = 1'b1;
        step();
        // Pointer back at 0: input 1 wins again, out0 lock is gone.
        total++;
        if (allocVector !== 25'h40) begin
            bad++;
            $display("FAIL reset_post_alloc: got %h expected %h", allocVector, 25'h40);
        end
        total++;
        if (lockVector !== 5'b0) begin
            bad++;
            $display("FAIL reset_post_lock: got %b expected %b", lockVector, 5'b0);
        end
        total++;
        if (grantValid !== 5'b00010) begin
            bad++;
            $display("FAIL reset_post_gv: got %b expected %b", grantValid, 5'b00010);
        end
        $display("tx reset_post alloc=%h gv=%b lock=%b", allocVector, grantValid, lockVector);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_fairness();
        logic [N*N-1:0] expv [6];
        logic [N-1:0]   expg [6];
        expv = '{25'h1, 25'h20, 25'h400, 25'h8000, 25'h100000, 25'h1};
        expg = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        apply_reset();
        reqVector  = (25'h1 << 0) | (25'h1 << 5) | (25'h1 << 10) | (25'h1 << 15) | (25'h1 << 20);
        tailVector = 5'b11111;
        outReady   = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            step();
            total++;
            if (allocVector !== expv[k]) begin
                bad++;
                $display("FAIL fair_alloc[%0d]: got %h expected %h", k, allocVector, expv[k]);
            end
            total++;
            if (grantValid !== expg[k]) begin
                bad++;
                $display("FAIL fair_gv[%0d]: got %b expected %b", k, grantValid, expg[k]);
            end
            $display("tx fair[%0d] alloc=%h gv=%b", k, allocVector, grantValid);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_permutation();
        apply_reset();
        reqVector  = (25'h1 << 1) | (25'h1 << 7) | (25'h1 << 13) | (25'h1 << 19) | (25'h1 << 20);
        tailVector = 5'b11111;
        step();
        total++;
        if (allocVector !== 25'h182082) begin
            bad++;
            $display("FAIL perm_alloc: got %h expected %h", allocVector, 25'h182082);
        end
        total++;
        if (grantValid !== 5'b11111) begin
            bad++;
            $display("FAIL perm_gv: got %b expected %b", grantValid, 5'b11111);
        end
        total++;
        if (lockVector !== 5'b0) begin
            bad++;
            $display("FAIL perm_lock: got %b expected %b", lockVector, 5'b0);
        end
        $display("tx perm alloc=%h gv=%b lock=%b", allocVector, grantValid, lockVector);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_wormhole();
        logic [N*N-1:0] expv [4];
        logic [N-1:0]   expl [4];
        apply_reset();
        // Single flit from input 1 moves ptr[4] to 2 so input 2 wins next.
        reqVector  = 25'h1 << 9;
        tailVector = 5'b00010;
        step();
        total++;
        if (allocVector !== 25'h200) begin
            bad++;
            $display("FAIL worm_prime: got %h expected %h", allocVector, 25'h200);
        end
        $display("tx worm_prime alloc=%h", allocVector);

        expv = '{25'h4000, 25'h4000, 25'h4000, 25'h10};
        expl = '{5'b10000, 5'b10000, 5'b00000, 5'b00000};
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                reqVector  = (25'h1 << 14) | (25'h1 << 4);
                tailVector = (k == 2) ? 5'b00101 : 5'b00001;
            end else begin
                reqVector  = 25'h1 << 4;
                tailVector = 5'b00001;
            end
            step();
            total++;
            if (allocVector !== expv[k]) begin
                bad++;
                $display("FAIL worm_alloc[%0d]: got %h expected %h", k, allocVector, expv[k]);
            end
            total++;
            if (lockVector !== expl[k]) begin
                bad++;
                $display("FAIL worm_lock[%0d]: got %b expected %b", k, lockVector, expl[k]);
            end
            $display("tx worm[%0d] alloc=%h lock=%b", k, allocVector, lockVector);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure();
        apply_reset();
        reqVector  = (25'h1 << 8) | (25'h1 << 23);
        tailVector = 5'b10000;
        step();
        total++;
        if (allocVector !== 25'h100) begin
            bad++;
            $display("FAIL bp_head: got %h expected %h", allocVector, 25'h100);
        end
        $display("tx bp_head alloc=%h lock=%b", allocVector, lockVector);

        outReady = 5'b10111;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (allocVector !== 25'h0) begin
                bad++;
                $display("FAIL bp_stall_alloc[%0d]: got %h expected %h", k, allocVector, 25'h0);
            end
            total++;
            if (lockVector !== 5'b01000) begin
                bad++;
                $display("FAIL bp_stall_lock[%0d]: got %b expected %b", k, lockVector, 5'b01000);
            end
            $display("tx bp_stall[%0d] alloc=%h lock=%b", k, allocVector, lockVector);
        end

        outReady   = 5'b11111;
        tailVector = 5'b10010;
        step();
        total++;
        if (allocVector !== 25'h100) begin
            bad++;
            $display("FAIL bp_resume: got %h expected %h", allocVector, 25'h100);
        end
        $display("tx bp_resume alloc=%h lock=%b", allocVector, lockVector);

        reqVector = 25'h1 << 23;
        step();
        total++;
        if (allocVector !== 25'h800000) begin
            bad++;
            $display("FAIL bp_next: got %h expected %h", allocVector, 25'h800000);
        end
        $display("tx bp_next alloc=%h lock=%b", allocVector, lockVector);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_multibit();
        apply_reset();
        // in3 row 10110, in2 -> out4, in4 -> out2
        reqVector  = (25'h16 << 15) | (25'h1 << 14) | (25'h1 << 22);
        tailVector = 5'b11111;
        step();
        total++;
        if (allocVector !== 25'h414000) begin
            bad++;
            $display("FAIL multi_alloc: got %h expected %h", allocVector, 25'h414000);
        end
        total++;
        if (grantValid !== 5'b11100) begin
            bad++;
            $display("FAIL multi_gv: got %b expected %b", grantValid, 5'b11100);
        end
        $display("tx multi alloc=%h gv=%b", allocVector, grantValid);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_not_ready();
        logic [N*N-1:0] expv [5];
        apply_reset();
        reqVector  = (25'h1 << 5) | (25'h1 << 10);
        tailVector = 5'b11111;
        outReady   = 5'b11110;
        expv = '{25'h0, 25'h0, 25'h20, 25'h400, 25'h20};
        for (int k = 0; k < 5; k++) begin
            if (k == 2) outReady = 5'b11111;
            step();
            total++;
            if (allocVector !== expv[k]) begin
                bad++;
                $display("FAIL nrdy_alloc[%0d]: got %h expected %h", k, allocVector, expv[k]);
            end
            $display("tx nrdy[%0d] alloc=%h lock=%b", k, allocVector, lockVector);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        reqVector  = '0;
        tailVector = '0;
        outReady   = '1;
        test_reset();
        test_fairness();
        test_permutation();
        test_wormhole();
        test_backpressure();
        test_multibit();
        test_not_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
